// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32 front-end definitions: the bubble instruction,
//               the major opcodes seen by the hazard unit, and the fetch FSM
//               state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    // addi x0, x0, 0 : the canonical pipeline bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD = 7'h03;
    localparam logic [6:0] OP_IMM  = 7'h13;
    localparam logic [6:0] OP_JAL  = 7'h6f;
    localparam logic [6:0] OP_JALR = 7'h67;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register. Holds PC, instruction and valid bit
//               and exposes the decode fields used by the hazard unit.
//               Priority: flush > load > bubble (write_en) > hold.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               flush               - force NOP/valid=0 regardless of write_en
//               load                - capture load_pc/load_instr as valid
//               write_en            - 1 = register may change (bubble when
//                                     nothing is loaded), 0 = hold
//               load_pc, load_instr - incoming instruction and its PC
//               pc, pc4, instr, valid, opcode, rs1, rs2 - register contents
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            load,
    input  logic            write_en,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    output logic [31:0]     instr,
    output logic            valid,
    output logic [6:0]      opcode,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2
);

    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (flush) begin
            // PC is left as-is; a bubble's PC carries no meaning
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (load) begin
            r_pc    <= load_pc;
            r_instr <= load_instr;
            r_valid <= 1'b1;
        end else if (write_en) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end
    end

    assign pc     = r_pc;
    assign pc4    = r_pc + XLEN'(4);
    assign instr  = r_instr;
    assign valid  = r_valid;
    assign opcode = r_instr[6:0];
    assign rs1    = r_instr[19:15];
    assign rs2    = r_instr[24:20];

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// Module      : instruction_fetch_stage
// Description : Fetch stage with IF/ID register. Issues one instruction-memory
//               read at a time over req/ready/rvalid, buffers one returned
//               word while the pipeline is stalled, and handles EX-stage
//               redirects (including dropping a read already in flight).
// Ports       : clk, rst_n                 - clock, sync active-low reset
//               PC_Write, IF_ID_REG_Write  - hazard-unit stall controls
//               branch_taken, branch_target- EX-stage redirect
//               imem_req/addr/ready        - read request channel
//               imem_rvalid/rdata          - read response channel
//               IF_ID_*, OPCODE            - IF/ID register contents
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PC_Write,
    input  logic            IF_ID_REG_Write,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] IF_ID_PC,
    output logic [XLEN-1:0] IF_ID_PC4,
    output logic [31:0]     IF_ID_instr,
    output logic            IF_ID_valid,
    output logic [6:0]      OPCODE,
    output logic [4:0]      IF_ID_rs1,
    output logic [4:0]      IF_ID_rs2
);

    import riscv_pkg::*;

    localparam logic [1:0] c_ST_FETCH = FETCH;
    localparam logic [1:0] c_ST_WAIT  = WAIT;
    localparam logic [1:0] c_ST_HOLD  = HOLD;

    logic [1:0]      r_state;
    logic            r_kill;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_buf;

    logic            w_advance;
    logic            w_deliver;
    logic [31:0]     w_deliver_instr;
    logic [XLEN-1:0] w_redirect_pc;

    always_comb begin
        w_advance       = PC_Write & IF_ID_REG_Write;
        // A redirect overrides any delivery in the same cycle.
        w_deliver       = 1'b0;
        w_deliver_instr = imem_rdata;
        if (!branch_taken && w_advance) begin
            if (r_state == c_ST_WAIT && imem_rvalid && !r_kill) begin
                w_deliver = 1'b1;
            end else if (r_state == c_ST_HOLD) begin
                w_deliver       = 1'b1;
                w_deliver_instr = r_buf;
            end
        end
        w_redirect_pc = branch_target & ~{{(XLEN-2){1'b0}}, 2'b11};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_state <= c_ST_FETCH;
            r_kill  <= 1'b0;
            r_buf   <= NOP_INSTR;
        end else if (branch_taken) begin
            r_pc <= w_redirect_pc;
            case (r_state)
                c_ST_FETCH: begin
                    // Request accepted this edge still targets the old path:
                    // its response must be thrown away.
                    if (imem_ready) begin
                        r_state <= c_ST_WAIT;
                        r_kill  <= 1'b1;
                    end
                end
                c_ST_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= c_ST_FETCH;
                        r_kill  <= 1'b0;
                    end else begin
                        r_kill  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_FETCH;
                    r_kill  <= 1'b0;
                end
            endcase
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    if (imem_ready) begin
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_kill) begin
                            r_state <= c_ST_FETCH;
                            r_kill  <= 1'b0;
                        end else if (w_advance) begin
                            r_pc    <= r_pc + XLEN'(4);
                            r_state <= c_ST_FETCH;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_state <= c_ST_HOLD;
                        end
                    end
                end
                c_ST_HOLD: begin
                    if (w_advance) begin
                        r_pc    <= r_pc + XLEN'(4);
                        r_state <= c_ST_FETCH;
                    end
                end
                default: begin
                    r_state <= c_ST_FETCH;
                    r_kill  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = (r_state == c_ST_FETCH);
    assign imem_addr = r_pc;

    if_id_reg #(
        .XLEN      (XLEN),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (branch_taken),
        .load       (w_deliver),
        .write_en   (IF_ID_REG_Write),
        .load_pc    (r_pc),
        .load_instr (w_deliver_instr),
        .pc         (IF_ID_PC),
        .pc4        (IF_ID_PC4),
        .instr      (IF_ID_instr),
        .valid      (IF_ID_valid),
        .opcode     (OPCODE),
        .rs1        (IF_ID_rs1),
        .rs2        (IF_ID_rs2)
    );

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// Module      : tb_instruction_fetch_stage
// Description : Self-checking bench for instruction_fetch_stage. A memory
//               responder drives the read channel; a transaction-level model
//               predicts request and IF/ID contents and is compared against
//               the DUT every cycle, plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, pw, iw, br, ready, rv;
    logic [31:0] tgt, rd;
    logic        imem_req, IF_ID_valid;
    logic [31:0] imem_addr, IF_ID_PC, IF_ID_PC4, IF_ID_instr;
    logic [6:0]  OPCODE;
    logic [4:0]  IF_ID_rs1, IF_ID_rs2;

    instruction_fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .PC_Write        (pw),
        .IF_ID_REG_Write (iw),
        .branch_taken    (br),
        .branch_target   (tgt),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (ready),
        .imem_rvalid     (rv),
        .imem_rdata      (rd),
        .IF_ID_PC        (IF_ID_PC),
        .IF_ID_PC4       (IF_ID_PC4),
        .IF_ID_instr     (IF_ID_instr),
        .IF_ID_valid     (IF_ID_valid),
        .OPCODE          (OPCODE),
        .IF_ID_rs1       (IF_ID_rs1),
        .IF_ID_rs2       (IF_ID_rs2)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return {a[26:2], 7'h13};
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_buf_w, e_pc, e_instr;
    logic        m_out, m_stale, m_buf_v, e_valid;

    task automatic model_step();
        logic        adv, acc, resp, del;
        logic [31:0] w;
        if (!rst_n) begin
            m_pc = RPC; m_out = 0; m_stale = 0; m_buf_v = 0; m_buf_w = NOP;
            e_pc = RPC; e_instr = NOP; e_valid = 0;
            return;
        end
        adv  = pw & iw;
        acc  = !m_out && !m_buf_v && ready;
        resp = m_out && rv;
        del  = 0;
        w    = rd;
        if (br) begin
            m_pc = tgt & ~32'h3; m_buf_v = 0; e_instr = NOP; e_valid = 0;
            if (acc) begin m_out = 1; m_stale = 1; end
            else if (resp) begin m_out = 0; m_stale = 0; end
            else if (m_out) m_stale = 1;
        end else begin
            if (acc) begin
                m_out = 1; m_stale = 0;
            end else if (resp) begin
                m_out = 0;
                if (!m_stale) begin
                    if (adv) del = 1;
                    else begin m_buf_v = 1; m_buf_w = rd; end
                end
                m_stale = 0;
            end else if (m_buf_v && adv) begin
                del = 1; w = m_buf_w; m_buf_v = 0;
            end
            if (del) begin
                e_pc = m_pc; e_instr = w; e_valid = 1; m_pc = m_pc + 32'd4;
            end else if (iw) begin
                e_instr = NOP; e_valid = 0;
            end
        end
    endtask

    // ---------------- memory responder + cycle driver ----------------
    logic        rsp_pend = 0;
    logic [31:0] rsp_addr = 0;
    int          rsp_cnt = 0;
    logic        rand_mode = 0, spur_en = 0, ready_off = 0, chk_en = 0;
    int          fixed_lat = 0;

    task automatic tick();
        logic        acc;
        logic [31:0] acc_addr;
        rv = 0;
        rd = $urandom;
        if (rsp_pend && rsp_cnt == 0) begin
            rv = 1; rd = mem_word(rsp_addr);
        end else if (!rsp_pend && spur_en && $urandom_range(0, 19) == 0) begin
            rv = 1;
        end
        if (rsp_pend || ready_off) ready = 0;
        else if (rand_mode) ready = 1'($urandom_range(0, 1));
        else ready = 1;
        acc      = (imem_req === 1'b1) && ready;
        acc_addr = imem_addr;
        @(posedge clk);
        model_step();
        if (rsp_pend) begin
            if (rsp_cnt == 0) rsp_pend = 0;
            else rsp_cnt--;
        end
        if (acc) begin
            rsp_pend = 1; rsp_addr = acc_addr;
            rsp_cnt  = rand_mode ? $urandom_range(0, 2) : fixed_lat;
        end
        @(negedge clk);
    endtask

    // ---------------- per-cycle comparison ----------------
    logic exp_req;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_req = !m_out && !m_buf_v;
            chk("imem_req", imem_req, exp_req);
            if (exp_req) chk("imem_addr", imem_addr, m_pc);
            chk("IF_ID_valid", IF_ID_valid, e_valid);
            chk("IF_ID_instr", IF_ID_instr, e_instr);
            chk("OPCODE", OPCODE, e_instr[6:0]);
            chk("IF_ID_rs1", IF_ID_rs1, e_instr[19:15]);
            chk("IF_ID_rs2", IF_ID_rs2, e_instr[24:20]);
            if (e_valid) begin
                chk("IF_ID_PC", IF_ID_PC, e_pc);
                chk("IF_ID_PC4", IF_ID_PC4, e_pc + 32'd4);
            end
        end
    end

    initial begin
        rst_n = 0; pw = 1; iw = 1; br = 0; tgt = 0; rv = 0; ready = 0; rd = 0;
        ready_off = 1;
        tick();
        chk_en = 1;
        tick();
        chk("rst_valid", IF_ID_valid, 0);
        chk("rst_instr", IF_ID_instr, NOP);
        chk("rst_req", imem_req, 1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", IF_ID_PC, 32'h0);

        // basic streaming: 2 cycles per instruction
        rst_n = 1; ready_off = 0;
        tick(); tick();
        chk("d_pc0", IF_ID_PC, 32'h0);
        chk("d_instr0", IF_ID_instr, 32'h0000_0093);
        chk("d_op0", OPCODE, 7'h13);
        chk("d_rs1_0", IF_ID_rs1, 0);
        chk("d_valid0", IF_ID_valid, 1);
        tick(); tick();
        chk("d_pc4", IF_ID_PC, 32'h4);
        chk("d_rs2_4", IF_ID_rs2, 5'd1);
        chk("d_pc4_plus", IF_ID_PC4, 32'h8);

        // 3-cycle stall while addr 8 response arrives -> buffered
        pw = 0; iw = 0;
        tick(); tick(); tick();
        chk("stall_req", imem_req, 0);
        chk("stall_pc", IF_ID_PC, 32'h4);
        chk("stall_instr", IF_ID_instr, 32'h0010_0113);
        pw = 1; iw = 1;
        tick();
        chk("rel_pc", IF_ID_PC, 32'h8);
        chk("rel_instr", IF_ID_instr, 32'h0000_0113);
        chk("rel_valid", IF_ID_valid, 1);

        // redirect on the same edge addr 12 is accepted
        br = 1; tgt = 32'h0000_0102;
        tick();
        chk("br_valid", IF_ID_valid, 0);
        chk("br_req", imem_req, 0);
        br = 0;
        tick();
        chk("br_req2", imem_req, 1);
        chk("br_addr", imem_addr, 32'h0000_0100);
        chk("br_valid2", IF_ID_valid, 0);
        tick(); tick();
        chk("br_pc", IF_ID_PC, 32'h0000_0100);
        chk("br_instr", IF_ID_instr, 32'h0000_2013);

        // redirect while HOLD and IF/ID write disabled
        pw = 0; iw = 0;
        tick(); tick();
        br = 1; tgt = 32'h0000_0200;
        tick();
        chk("hbr_valid", IF_ID_valid, 0);
        chk("hbr_instr", IF_ID_instr, NOP);
        chk("hbr_req", imem_req, 1);
        chk("hbr_addr", imem_addr, 32'h0000_0200);
        br = 0; pw = 1; iw = 1;
        tick(); tick();
        chk("hbr_pc", IF_ID_PC, 32'h0000_0200);

        // redirect in FETCH without acceptance, then PC wrap
        ready_off = 1; br = 1; tgt = 32'hFFFF_FFFF;
        tick();
        chk("wr_req", imem_req, 1);
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        ready_off = 0; br = 0;
        tick(); tick();
        chk("wr_pc", IF_ID_PC, 32'hFFFF_FFFC);
        chk("wr_pc4", IF_ID_PC4, 32'h0);
        chk("wr_next_addr", imem_addr, 32'h0);

        // reset while a read is outstanding; response lands after reset
        fixed_lat = 1;
        tick();
        rst_n = 0;
        tick();
        chk("rw_addr", imem_addr, RPC);
        chk("rw_valid", IF_ID_valid, 0);
        rst_n = 1;
        tick();
        chk("rw_stale_valid", IF_ID_valid, 0);
        chk("rw_stale_req", imem_req, 1);
        fixed_lat = 0;
        tick(); tick();
        chk("rw_new_valid", IF_ID_valid, 1);
        chk("rw_new_pc", IF_ID_PC, RPC);

        // randomized phase
        rand_mode = 1; spur_en = 1;
        for (int i = 0; i < 4000; i++) begin
            pw    = ($urandom_range(0, 3) != 0);
            iw    = ($urandom_range(0, 3) != 0);
            br    = ($urandom_range(0, 12) == 0);
            tgt   = $urandom;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
Fetch stage plus IF/ID pipeline register. Issues instruction-memory reads over a req/ready/rvalid handshake and holds the current PC. Presents the IF/ID register contents, including the opcode, rs1 and rs2 fields consumed by the hazard detection unit. Honours that unit's PC_Write and IF_ID_REG_Write stall controls and the EX-stage branch redirect.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
PC_Write  in  1  from hazard unit; 0 = PC must not advance
IF_ID_REG_Write  in  1  from hazard unit; 0 = IF/ID register holds
branch_taken  in  1  EX-stage redirect request
branch_target  in  XLEN  redirect address
imem_req  out  1  read request valid
imem_addr  out  XLEN  read address; stable while imem_req=1 and imem_ready=0
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  instruction word
IF_ID_PC  out  XLEN  PC of instruction in IF/ID
IF_ID_PC4  out  XLEN  IF_ID_PC+4
IF_ID_instr  out  32  instruction in IF/ID
IF_ID_valid  out  1  IF/ID holds a real instruction
OPCODE  out  7  IF_ID_instr[6:0]
IF_ID_rs1  out  5  IF_ID_instr[19:15]
IF_ID_rs2  out  5  IF_ID_instr[24:20]

Behaviour:
- Reset (rst_n=0 at clk edge), all registered state:
  - pc=RESET_PC; state=FETCH; kill=0.
  - IF_ID_instr=NOP_INSTR; IF_ID_valid=0; IF_ID_PC=RESET_PC.
  - imem_req is 1 in the first cycle after reset.
- At most one request outstanding.
- imem_rvalid is sampled only in WAIT. A response arriving in any other state, including one in flight across a reset, is ignored.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc. imem_ready=1 -> WAIT.
  - WAIT: imem_req=0. On imem_rvalid:
    - kill=1: discard data, clear kill -> FETCH.
    - else if advance (PC_Write & IF_ID_REG_Write): IF/ID <= {pc, rdata, valid=1}; pc <= pc+4 -> FETCH.
    - else: latch rdata into a 1-entry buffer -> HOLD.
  - HOLD: on advance, IF/ID <= {pc, buffer, valid=1}; pc <= pc+4 -> FETCH.
- Bubble insertion: when IF_ID_REG_Write=1 and no instruction is delivered that cycle, IF/ID gets NOP_INSTR with valid=0. When IF_ID_REG_Write=0, IF/ID holds unchanged.
- Redirect (branch_taken=1) has highest priority over stall and delivery:
  - pc <= {branch_target[XLEN-1:2], 2'b00}.
  - IF/ID flushed to NOP, valid=0, even if IF_ID_REG_Write=0.
  - FETCH, imem_ready=0 -> stay in FETCH; the new address is driven next cycle.
  - FETCH, imem_ready=1 -> WAIT with kill=1 (accepted old request must be dropped).
  - WAIT, no rvalid -> kill=1, stay in WAIT.
  - WAIT, rvalid same cycle -> discard data -> FETCH.
  - HOLD -> buffer discarded -> FETCH.
- PC arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- Latency: instruction appears in IF/ID on the edge where rvalid is sampled (with advance). Peak throughput is 1 instruction per 2 cycles.
- OPCODE, IF_ID_rs1 and IF_ID_rs2 are combinational slices of the IF/ID register, with no extra delay.

Decomposition:
- Shared package riscv_pkg holds:
  - NOP_INSTR constant
  - opcode constants (OP_LOAD 7'h03, OP_IMM 7'h13, OP_JAL 7'h6f, OP_JALR 7'h67)
  - fetch_state_t enum {FETCH, WAIT, HOLD}
- One natural sub-module: if_id_reg. It holds the PC/instr/valid register with hold, load and flush controls and generates the field slices.

Test Plan:
- Reset then imem_ready=1 always, rvalid one cycle after acceptance, rdata=32'h0000_0093 at addr 0 and 32'h0010_0113 at addr 4 -> IF_ID_PC 0 then 4; OPCODE=7'h13; IF_ID_rs1=0.
- Hold PC_Write=IF_ID_REG_Write=0 for 3 cycles while the response for addr 8 arrives -> state HOLD; IF/ID unchanged; on release, IF_ID_PC=8 and the buffered word is loaded.
- branch_taken=1, target 32'h0000_0102, in the same cycle imem_ready accepts addr 12; stale rvalid arrives next -> stale data dropped; next imem_addr=32'h0000_0100; IF_ID_valid=0 for the flush cycle.
- branch_taken during HOLD with IF_ID_REG_Write=0 -> IF/ID becomes NOP/valid=0; buffer discarded; fetch from the target.
- pc=32'hFFFF_FFFC, fetch completes -> next imem_addr=0.
- rst_n=0 while in WAIT, response arrives the cycle after reset deasserts -> ignored; imem_addr=RESET_PC; IF_ID_valid stays 0 until the new response.
